multi_cycle_ctrl: RTL and testbench

Multi-cycle MIPS control FSM. It sequences the shared ALU, unified instruction/data memory and register file over several cycles per instruction. It covers the opcode set RTYPE, LW, SW, BEQ, ADDI and J, and adds memory wait states through a mem_ready handshake. It sits beside the multi-cycle datapath and the existing ALU decoder, which consumes alu_op.

---
 rtl/ctrl_pkg.sv | 66 ++++++
 rtl/multi_cycle_ctrl_out_dec.sv | 74 +++++++
 rtl/multi_cycle_ctrl.sv | 111 +++++++++++
 tb/tb_multi_cycle_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control constants for the MIPS controllers.
// Opcodes, state encodings, mux codes, control vector.
package ctrl_pkg;

  localparam int OP_W = 6;
  localparam int ST_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  typedef enum logic [ST_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EX   = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
  } ctrl_t;

  function automatic logic op_legal(
    input logic [OP_W-1:0] op
  );
    return (op == OP_RTYPE) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_out_dec.sv
// State to control-vector decoder for the multi-cycle FSM.
// Ungated values; handshake and flag gating live in the top.
module ctrl_out_dec
  import ctrl_pkg::*;
(
  input  logic [ST_W-1:0] i_state,
  output ctrl_t           o_ctrl
);

  // Per-state control vector; unlisted fields and states stay 0
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.pc_en     = 1'b1;
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.pc_src    = PC_ALU;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADR, S_ADDI_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        o_ctrl.i_or_d = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        o_ctrl.i_or_d     = 1'b1;
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_EXECUTE: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REGB;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALU_WB: begin
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a  = 1'b1;
        o_ctrl.alu_src_b  = SRCB_REGB;
        o_ctrl.alu_op     = ALU_SUB;
        o_ctrl.pc_src     = PC_ALUOUT;
        o_ctrl.pc_en      = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_src     = PC_JUMP;
        o_ctrl.pc_en      = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory wait states.
// Moore outputs gated by mem_ready, zero and reset.
module multi_cycle_ctrl
  import ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_en,
  output logic            ir_write,
  output logic            i_or_d,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_src,
  output logic            illegal_op,
  output logic            instr_done,
  output logic [ST_W-1:0] state
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_cv;

  ctrl_out_dec u_dec (
    .i_state (r_state),
    .o_ctrl  (w_cv)
  );

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state sequencing per instruction class
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:
        w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op == OP_RTYPE)
          w_next = S_EXECUTE;
        else if (op == OP_LW || op == OP_SW)
          w_next = S_MEM_ADR;
        else if (op == OP_BEQ)
          w_next = S_BRANCH;
        else if (op == OP_ADDI)
          w_next = S_ADDI_EX;
        else if (op == OP_J)
          w_next = S_JUMP;
        else
          w_next = S_FETCH;
      end
      S_MEM_ADR:
        w_next = (op == OP_LW) ? S_MEM_READ
                               : S_MEM_WRITE;
      S_MEM_READ:
        w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE:
        w_next = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE: w_next = S_ALU_WB;
      S_ADDI_EX: w_next = S_ADDI_WB;
      default:   w_next = S_FETCH;
    endcase
  end

  // Output gating by handshake, branch flag and reset
  always_comb begin
    pc_en      = w_cv.pc_en;
    ir_write   = w_cv.ir_write;
    i_or_d     = w_cv.i_or_d;
    mem_write  = w_cv.mem_write;
    mem_to_reg = w_cv.mem_to_reg;
    reg_dst    = w_cv.reg_dst;
    reg_write  = w_cv.reg_write;
    alu_src_a  = w_cv.alu_src_a;
    alu_src_b  = w_cv.alu_src_b;
    alu_op     = w_cv.alu_op;
    pc_src     = w_cv.pc_src;
    instr_done = w_cv.instr_done;
    illegal_op = (r_state == S_DECODE) &&
                 !op_legal(op);
    if (r_state == S_FETCH) begin
      pc_en    = mem_ready;
      ir_write = mem_ready;
    end
    if (r_state == S_BRANCH)
      pc_en = zero;
    if (r_state == S_MEM_WRITE)
      instr_done = mem_ready;
    if (!rst_n) begin
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl.
// Directed scenarios plus random instruction streams.
module tb_multi_cycle_ctrl;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = OP_LW;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_en, ir_write, i_or_d, mem_write;
  logic       mem_to_reg, reg_dst, reg_write;
  logic       alu_src_a, illegal_op, instr_done;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multi_cycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .ir_write   (ir_write),
    .i_or_d     (i_or_d),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .illegal_op (illegal_op),
    .instr_done (instr_done),
    .state      (state)
  );

  task automatic drive(input logic mr, input logic z);
    mem_ready = mr;
    zero = z;
    @(negedge clk);
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    adv();
    adv();
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] obs();
    return {pc_en, ir_write, i_or_d, mem_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a,
            alu_src_b, alu_op, pc_src,
            illegal_op, instr_done};
  endfunction

  function automatic logic is_legal(input logic [5:0] o);
    return o inside {OP_RTYPE, OP_LW, OP_SW,
                     OP_BEQ, OP_ADDI, OP_J};
  endfunction

  // Expected control outputs from the per-state table
  function automatic logic [15:0] exp_out(
    input int st, input logic mr,
    input logic z, input logic [5:0] o
  );
    logic pe, iw, iod, mw, m2r, rd, rw, sa, ill, dn;
    logic [1:0] sb, ao, ps;
    {pe, iw, iod, mw, m2r, rd, rw, sa, ill, dn} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      0:  begin sb = 2'b01; pe = mr; iw = mr; end
      1:  begin sb = 2'b11; ill = !is_legal(o); end
      2:  begin sa = 1; sb = 2'b10; end
      3:  iod = 1;
      4:  begin m2r = 1; rw = 1; dn = 1; end
      5:  begin iod = 1; mw = 1; dn = mr; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rd = 1; rw = 1; dn = 1; end
      8:  begin
            sa = 1; ao = 2'b01; ps = 2'b01;
            pe = z; dn = 1;
          end
      9:  begin sa = 1; sb = 2'b10; end
      10: begin rw = 1; dn = 1; end
      11: begin ps = 2'b10; pe = 1; dn = 1; end
      default: ;
    endcase
    return {pe, iw, iod, mw, m2r, rd, rw, sa,
            sb, ao, ps, ill, dn};
  endfunction

  // Expected state trace of one instruction
  task automatic build_seq(
    input logic [5:0] o, input int fw, input int mw,
    output int q[$]
  );
    q = {};
    repeat (fw + 1) q.push_back(0);
    q.push_back(1);
    case (o)
      OP_RTYPE: begin q.push_back(6); q.push_back(7); end
      OP_LW: begin
        q.push_back(2);
        repeat (mw + 1) q.push_back(3);
        q.push_back(4);
      end
      OP_SW: begin
        q.push_back(2);
        repeat (mw + 1) q.push_back(5);
      end
      OP_BEQ:  q.push_back(8);
      OP_ADDI: begin q.push_back(9); q.push_back(10); end
      OP_J:    q.push_back(11);
      default: ;
    endcase
  endtask

  task automatic test_reset;
    logic [5:0] s;
    rst_n = 1'b0;
    op = OP_LW;
    adv();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0);
      s = {pc_en, ir_write, mem_write,
           reg_write, illegal_op, instr_done};
      n_checks++;
      if (state !== 4'd0 || s !== 6'd0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d state=%0d strobes=%b exp state=0 strobes=000000",
                 i, state, s);
      end
      adv();
    end
    rst_n = 1'b1;
    drive(1'b1, 1'b0);
    n_checks++;
    if (ir_write !== 1'b1 || pc_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first ir_write=%b pc_en=%b exp 1 1",
               ir_write, pc_en);
    end
    adv();
    drive(1'b1, 1'b0);
    n_checks++;
    if (state !== 4'd1) begin
      n_fail++;
      $display("FAIL reset_decode state=%0d exp 1", state);
    end
  endtask

  task automatic test_lw;
    int exp_st[5] = '{0, 1, 2, 3, 4};
    do_reset();
    op = OP_LW;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0);
      n_checks++;
      if (state !== 4'(exp_st[i])) begin
        n_fail++;
        $display("FAIL lw_state cyc=%0d got=%0d exp=%0d",
                 i, state, exp_st[i]);
      end
      if (i == 4) begin
        n_checks++;
        if ({reg_write, mem_to_reg, reg_dst, instr_done}
            !== 4'b1101) begin
          n_fail++;
          $display("FAIL lw_wb rw,m2r,rd,dn=%b exp 1101",
                   {reg_write, mem_to_reg, reg_dst,
                    instr_done});
        end
      end
      adv();
    end
    drive(1'b1, 1'b0);
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL lw_end state=%0d exp 0", state);
    end
  endtask

  task automatic test_sw_wait;
    int cw = 0, cd = 0, di = -1, acc = 0;
    do_reset();
    op = OP_SW;
    for (int i = 0; i < 7; i++) begin
      drive((i < 3) || (i == 6), 1'b0);
      if (mem_write && i_or_d) cw++;
      if (instr_done) begin cd++; di = i; end
      if (mem_write && mem_ready) acc++;
      if (i == 3) begin
        n_checks++;
        if (state !== 4'd5) begin
          n_fail++;
          $display("FAIL sw_state got=%0d exp 5", state);
        end
      end
      adv();
    end
    n_checks++;
    if (cw != 4) begin
      n_fail++;
      $display("FAIL sw_write_cycles got=%0d exp 4", cw);
    end
    n_checks++;
    if (cd != 1 || di != 6) begin
      n_fail++;
      $display("FAIL sw_done count=%0d at=%0d exp 1 at 6",
               cd, di);
    end
    n_checks++;
    if (acc != 1) begin
      n_fail++;
      $display("FAIL sw_accepted got=%0d exp 1", acc);
    end
    drive(1'b1, 1'b0);
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL sw_end state=%0d exp 0", state);
    end
  endtask

  task automatic test_beq;
    do_reset();
    op = OP_BEQ;
    for (int z = 1; z >= 0; z--) begin
      drive(1'b1, 1'b0);
      adv();
      drive(1'b1, 1'b0);
      adv();
      drive(1'b1, 1'(z));
      n_checks++;
      if (state !== 4'd8 || pc_src !== 2'b01 ||
          pc_en !== 1'(z) || instr_done !== 1'b1) begin
        n_fail++;
        $display("FAIL beq z=%0d state=%0d pc_src=%b pc_en=%b done=%b exp 8 01 %0d 1",
                 z, state, pc_src, pc_en, instr_done, z);
      end
      adv();
    end
    drive(1'b1, 1'b0);
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL beq_end state=%0d exp 0", state);
    end
  endtask

  task automatic test_illegal;
    int wr = 0;
    do_reset();
    op = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0);
      if (reg_write || mem_write) wr++;
      n_checks++;
      if (illegal_op !== (i == 1)) begin
        n_fail++;
        $display("FAIL illegal_pulse cyc=%0d got=%b exp=%b",
                 i, illegal_op, (i == 1));
      end
      if (i == 2) begin
        n_checks++;
        if (state !== 4'd0) begin
          n_fail++;
          $display("FAIL illegal_next state=%0d exp 0",
                   state);
        end
      end
      adv();
    end
    n_checks++;
    if (wr != 0) begin
      n_fail++;
      $display("FAIL illegal_writes got=%0d exp 0", wr);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    op = OP_RTYPE;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) op = OP_J;
      drive(1'b1, 1'b0);
      if (i == 2) begin
        n_checks++;
        if (state !== 4'd6 || alu_op !== 2'b10) begin
          n_fail++;
          $display("FAIL rtype_exec state=%0d alu_op=%b exp 6 10",
                   state, alu_op);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (state !== 4'd7 || reg_dst !== 1'b1 ||
            reg_write !== 1'b1) begin
          n_fail++;
          $display("FAIL rtype_wb state=%0d rd=%b rw=%b exp 7 1 1",
                   state, reg_dst, reg_write);
        end
      end
      if (i == 6) begin
        n_checks++;
        if (state !== 4'd11 || pc_src !== 2'b10 ||
            pc_en !== 1'b1) begin
          n_fail++;
          $display("FAIL jump state=%0d pc_src=%b pc_en=%b exp 11 10 1",
                   state, pc_src, pc_en);
        end
      end
      adv();
    end
  endtask

  task automatic test_reset_mid;
    int wr = 0;
    do_reset();
    op = OP_LW;
    for (int i = 0; i < 4; i++) begin
      drive(i < 3, 1'b0);
      adv();
    end
    drive(1'b0, 1'b0);
    n_checks++;
    if (state !== 4'd3) begin
      n_fail++;
      $display("FAIL mid_state got=%0d exp 3", state);
    end
    adv();
    rst_n = 1'b0;
    drive(1'b0, 1'b0);
    if (reg_write) wr++;
    adv();
    rst_n = 1'b1;
    drive(1'b0, 1'b0);
    if (reg_write) wr++;
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset state=%0d exp 0", state);
    end
    n_checks++;
    if (wr != 0) begin
      n_fail++;
      $display("FAIL mid_reset_write got=%0d exp 0", wr);
    end
    adv();
  endtask

  task automatic test_random;
    logic [5:0] ops[6] = '{OP_RTYPE, OP_LW, OP_SW,
                           OP_BEQ, OP_ADDI, OP_J};
    int q[$];
    logic mr, z;
    logic [15:0] e;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 6) == 6) begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      build_seq(op, $urandom_range(0, 2),
                $urandom_range(0, 3), q);
      for (int i = 0; i < q.size(); i++) begin
        if (q[i] == 0 || q[i] == 3 || q[i] == 5)
          mr = (i + 1 == q.size()) || (q[i+1] != q[i]);
        else
          mr = 1'($urandom);
        z = 1'($urandom);
        drive(mr, z);
        e = exp_out(q[i], mr, z, op);
        n_checks++;
        if (state !== 4'(q[i]) || obs() !== e) begin
          n_fail++;
          $display("FAIL rnd k=%0d cyc=%0d op=%b state=%0d exp_state=%0d out=%b exp_out=%b",
                   k, i, op, state, q[i], obs(), e);
        end
        adv();
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
